// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational read ports
// with optional write bypass and zero register, plus a handshaked register dump engine.
module regfile_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_W-1:0] reg_q [DEPTH];
  logic              wr_en_c;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_valid_q, dump_valid_d;
  logic              dump_busy_q, dump_busy_d;
  logic              dump_done_q, dump_done_d;

  logic [ADDR_W-1:0] load_idx_c;
  logic [DATA_W-1:0] load_val_c;

  // Writes to the hardwired zero register are dropped before they reach storage or bypass.
  assign wr_en_c = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      reg_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = reg_q[raddr1];
    if ((BYPASS != 0) && wr_en_c && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
    if (rst || ((ZERO_REG != 0) && (raddr1 == '0))) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = reg_q[raddr2];
    if ((BYPASS != 0) && wr_en_c && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
    if (rst || ((ZERO_REG != 0) && (raddr2 == '0))) begin
      rdata2 = '0;
    end
  end

  // Value a beat captures on load: post-edge register contents, so a same-cycle write is included.
  always_comb begin
    load_idx_c = (state_q == S_SCAN) ? (dump_addr_q + ADDR_W'(1)) : '0;
    load_val_c = reg_q[load_idx_c];
    if (wr_en_c && (waddr == load_idx_c)) begin
      load_val_c = wdata;
    end
    if ((ZERO_REG != 0) && (load_idx_c == '0)) begin
      load_val_c = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d     = S_SCAN;
          dump_addr_d = '0;
          dump_data_d = load_val_c;
        end
      end
      S_SCAN: begin
        if (dump_ready) begin
          if (dump_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            dump_addr_d = load_idx_c;
            dump_data_d = load_val_c;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dump_valid_d = (state_d == S_SCAN);
    dump_busy_d  = (state_d != S_IDLE);
    dump_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_busy_q  <= dump_busy_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_valid = dump_valid_q;
  assign dump_busy  = dump_busy_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: two builds (plain/no-bypass and zero-reg/bypass) driven
// in lockstep, dump beats checked against a scoreboard of expected beats.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr1, raddr2;
  logic        dump_start, dump_ready;

  logic [15:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic        a_busy, a_valid, a_done, b_busy, b_valid, b_done;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] da;
    logic [15:0] db;
  } beat_t;

  beat_t       q[$];
  logic [15:0] ma[8];
  logic [15:0] mb[8];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          beats    = 0;
  logic        held     = 1'b0;
  logic [2:0]  held_addr;
  logic [15:0] held_da, held_db;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(a_rdata1), .raddr2(raddr2), .rdata2(a_rdata2),
    .dump_start(dump_start), .dump_busy(a_busy), .dump_valid(a_valid),
    .dump_ready(dump_ready), .dump_addr(a_addr), .dump_data(a_data), .dump_done(a_done)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(b_rdata1), .raddr2(raddr2), .rdata2(b_rdata2),
    .dump_start(dump_start), .dump_busy(b_busy), .dump_valid(b_valid),
    .dump_ready(dump_ready), .dump_addr(b_addr), .dump_data(b_data), .dump_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
    ma[a] = d;
    if (a != 3'd0) mb[a] = d;
  endtask

  task automatic push_dump();
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.addr = 3'(i); e.da = ma[i]; e.db = mb[i];
      q.push_back(e);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      ma[i] = 16'h0; mb[i] = 16'h0;
    end
  endtask

  // Beat monitor: pops the scoreboard on each accepted beat, checks stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (a_valid && dump_ready) begin
        if (q.size() == 0) begin
          chk("beat_unexpected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("beat_addr_a", 32'(a_addr), 32'(e.addr));
          chk("beat_data_a", 32'(a_data), 32'(e.da));
          chk("beat_addr_b", 32'(b_addr), 32'(e.addr));
          chk("beat_data_b", 32'(b_data), 32'(e.db));
          chk("beat_valid_b", 32'(b_valid), 32'd1);
          beats++;
        end
        held = 1'b0;
      end else if (a_valid) begin
        if (held) begin
          chk("stall_addr_a", 32'(a_addr), 32'(held_addr));
          chk("stall_data_a", 32'(a_data), 32'(held_da));
          chk("stall_data_b", 32'(b_data), 32'(held_db));
        end
        held = 1'b1; held_addr = a_addr; held_da = a_data; held_db = b_data;
      end else begin
        held = 1'b0;
      end
      if (a_done) done_cnt++;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    int dc0;
    int bt0;
    logic found;
    beat_t e;

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    clear_model();

    // T1: reset state, then fill with FFFF and reset again
    repeat (2) @(negedge clk);
    chk("rst_valid_a", 32'(a_valid), 32'd0);
    chk("rst_busy_a", 32'(a_busy), 32'd0);
    chk("rst_done_a", 32'(a_done), 32'd0);
    chk("rst_addr_a", 32'(a_addr), 32'd0);
    chk("rst_data_a", 32'(a_data), 32'd0);
    chk("rst_valid_b", 32'(b_valid), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    raddr1 = 3'd5; raddr2 = 3'd0; #1;
    chk("t1_fill_a", 32'(a_rdata1), 32'hFFFF);
    chk("t1_fill_b_zero", 32'(b_rdata2), 32'h0);
    @(negedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i); raddr2 = 3'(i); #1;
      chk("t1_rst_rd_a", 32'(a_rdata1), 32'h0);
      chk("t1_rst_rd_b", 32'(b_rdata2), 32'h0);
    end
    chk("t1_rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i); #1;
      chk("t1_post_rst_a", 32'(a_rdata1), 32'h0);
    end

    // T2: same-cycle read of the write address
    @(posedge clk); #1;
    we = 1'b1; waddr = 3'd3; wdata = 16'h1234; raddr1 = 3'd3;
    @(negedge clk);
    chk("t2_nobypass_a", 32'(a_rdata1), 32'h0);
    chk("t2_bypass_b", 32'(b_rdata1), 32'h1234);
    @(posedge clk); #1 we = 1'b0;
    ma[3] = 16'h1234; mb[3] = 16'h1234;
    @(negedge clk);
    chk("t2_next_a", 32'(a_rdata1), 32'h1234);
    chk("t2_next_b", 32'(b_rdata1), 32'h1234);

    // T3: register 0 write, hardwired zero in build b even under bypass
    @(posedge clk); #1;
    we = 1'b1; waddr = 3'd0; wdata = 16'hBEEF; raddr1 = 3'd0; raddr2 = 3'd0;
    @(negedge clk);
    chk("t3_old_a", 32'(a_rdata1), 32'h0);
    chk("t3_zero_byp_b1", 32'(b_rdata1), 32'h0);
    chk("t3_zero_byp_b2", 32'(b_rdata2), 32'h0);
    @(posedge clk); #1 we = 1'b0;
    ma[0] = 16'hBEEF;
    @(negedge clk);
    chk("t3_next_a", 32'(a_rdata1), 32'hBEEF);
    chk("t3_next_b", 32'(b_rdata1), 32'h0);

    // T4: full dump with ready tied high
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
    dump_ready = 1'b1;
    push_dump();
    bt0 = beats;
    dump_start = 1'b1;
    done_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1 dump_start = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        chk("t4_first_valid", 32'(a_valid), 32'd1);
        chk("t4_busy", 32'(a_busy), 32'd1);
      end
      if (a_done) begin
        done_cyc = c;
        break;
      end
    end
    chk("t4_done_cycle", 32'(done_cyc), 32'd9);
    chk("t4_done_busy", 32'(a_busy), 32'd1);
    chk("t4_done_b", 32'(b_done), 32'd1);
    chk("t4_beats", 32'(beats - bt0), 32'd8);
    chk("t4_queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("t4_done_pulse", 32'(a_done), 32'd0);
    chk("t4_idle_busy", 32'(a_busy), 32'd0);

    // T5: backpressure with writes during the stall and a start pulse mid-scan
    @(posedge clk); #1;
    push_dump();
    e = q[2]; e.da = 16'hAAAA; e.db = 16'hAAAA; q[2] = e;
    bt0 = beats;
    dump_ready = 1'b1; dump_start = 1'b1;
    done_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      dump_start = 1'b0; we = 1'b0; dump_ready = 1'b1;
      if (c == 2) begin
        dump_ready = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 16'hAAAA;
      end else if (c == 3) begin
        dump_ready = 1'b0; we = 1'b1; waddr = 3'd1; wdata = 16'h5555; dump_start = 1'b1;
      end
      @(negedge clk);
      if (a_done) begin
        done_cyc = c;
        break;
      end
    end
    we = 1'b0;
    ma[2] = 16'hAAAA; mb[2] = 16'hAAAA; ma[1] = 16'h5555; mb[1] = 16'h5555;
    chk("t5_done_cycle", 32'(done_cyc), 32'd11);
    chk("t5_beats", 32'(beats - bt0), 32'd8);
    chk("t5_queue_empty", 32'(q.size()), 32'd0);
    raddr1 = 3'd1; raddr2 = 3'd2; #1;
    chk("t5_reg1_a", 32'(a_rdata1), 32'h5555);
    chk("t5_reg2_b", 32'(b_rdata2), 32'hAAAA);

    // T6: reset during a dump
    @(posedge clk); #1;
    push_dump();
    dump_ready = 1'b1; dump_start = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1 dump_start = 1'b0;
      @(negedge clk);
      if (a_valid && (a_addr == 3'd4)) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reach_addr4", 32'(found), 32'd1);
    dc0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("t6_valid_a", 32'(a_valid), 32'd0);
    chk("t6_busy_a", 32'(a_busy), 32'd0);
    chk("t6_addr_a", 32'(a_addr), 32'd0);
    chk("t6_valid_b", 32'(b_valid), 32'd0);
    q.delete();
    clear_model();
    @(negedge clk); #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'(dc0));
    chk("t6_idle_busy", 32'(a_busy), 32'd0);
    chk("t6_idle_valid", 32'(a_valid), 32'd0);
    raddr1 = 3'd5; #1;
    chk("t6_regs_cleared", 32'(a_rdata1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
